// File: rtl/fan_pkg.sv
// Shared FAN definitions: FP32 field positions, constants and the accumulator state encoding.
package fan_pkg;

  localparam int FP32_W       = 32;
  localparam int FP32_EXP_MSB = 30;
  localparam int FP32_EXP_LSB = 23;
  localparam logic [FP32_W-1:0] FP32_ZERO = 32'h0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  // All-ones exponent marks Inf or NaN.
  function automatic logic is_exp_max(input logic [FP32_W-1:0] v);
    return &v[FP32_EXP_MSB:FP32_EXP_LSB];
  endfunction

endpackage

// File: rtl/fp32adder.sv
// Combinational FP32 adder: round-to-nearest-even, gradual underflow, quiet-NaN output on invalid ops.
module fp32adder
  import fan_pkg::*;
(
  input  logic [FP32_W-1:0] a,
  input  logic [FP32_W-1:0] b,
  output logic [FP32_W-1:0] y
);

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    n = 5'd27;
    for (int i = 0; i < 27; i++) if (v[i]) n = 5'(26 - i);
    return n;
  endfunction

  logic              a_big, eff_sub, inc;
  logic              a_nan, b_nan, a_inf, b_inf;
  logic [31:0]       x, yv;
  logic [7:0]        ex, ey, d;
  logic [23:0]       mx, my, m;
  logic [26:0]       yfull, ysh, nrm;
  logic [27:0]       sum;
  logic [9:0]        e, e2;
  logic [4:0]        lz, sh;
  logic [24:0]       r;

  always_comb begin
    a_big = a[30:0] >= b[30:0];
    x     = a_big ? a : b;
    yv    = a_big ? b : a;
    ex    = (x[30:23] == 8'd0)  ? 8'd1 : x[30:23];
    ey    = (yv[30:23] == 8'd0) ? 8'd1 : yv[30:23];
    mx    = {x[30:23] != 8'd0, x[22:0]};
    my    = {yv[30:23] != 8'd0, yv[22:0]};
    d     = ex - ey;

    // Align the smaller operand, folding shifted-out bits into a sticky bit.
    yfull = {my, 3'b000};
    if (d >= 8'd27) ysh = {26'b0, |my};
    else            ysh = (yfull >> d) | {26'b0, |(yfull & ~({27{1'b1}} << d))};

    eff_sub = x[31] ^ yv[31];
    sum     = eff_sub ? ({1'b0, mx, 3'b000} - {1'b0, ysh})
                      : ({1'b0, mx, 3'b000} + {1'b0, ysh});

    lz  = lzc27(sum[26:0]);
    sh  = 5'd0;
    nrm = sum[26:0];
    e   = {2'b00, ex};
    if (sum[27]) begin
      nrm = {sum[27:2], sum[1] | sum[0]};
      e   = {2'b00, ex} + 10'd1;
    end else begin
      // Left shift stops at exponent 1 so tiny results become denormals.
      if ({3'b000, lz} < ex) sh = lz;
      else                   sh = 5'(ex - 8'd1);
      nrm = sum[26:0] << sh;
      e   = {2'b00, ex} - {5'b00000, sh};
    end

    inc = nrm[2] & (nrm[1] | nrm[0] | nrm[3]);
    r   = {1'b0, nrm[26:3]} + {24'b0, inc};
    if (r[24]) begin
      m  = r[24:1];
      e2 = e + 10'd1;
    end else begin
      m  = r[23:0];
      e2 = e;
    end

    a_nan = is_exp_max(a) & (|a[22:0]);
    b_nan = is_exp_max(b) & (|b[22:0]);
    a_inf = is_exp_max(a) & ~(|a[22:0]);
    b_inf = is_exp_max(b) & ~(|b[22:0]);

    y = FP32_ZERO;
    if (a_nan || b_nan || (a_inf && b_inf && (a[31] ^ b[31]))) y = 32'h7FC0_0000;
    else if (a_inf)            y = a;
    else if (b_inf)            y = b;
    else if (sum == 28'd0)     y = {~eff_sub & x[31], 31'b0};
    else if (e2 >= 10'd255)    y = {x[31], 8'hFF, 23'b0};
    else                       y = {x[31], m[23] ? e2[7:0] : 8'h00, m[22:0]};
  end

endmodule

// File: rtl/fan_psum_accum.sv
// Temporal accumulator for FAN node partial sums: folds LEN FP32 beats into one total behind valid/ready.
// Optional sticky Inf/NaN indicator enabled by FAN_ACC_NAN_FLAG_EN.
module fan_psum_accum
  import fan_pkg::*;
#(
  parameter int DW    = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic             busy
`ifdef FAN_ACC_NAN_FLAG_EN
  ,output logic            nan_flag
`endif
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state;
  logic [DW-1:0]    acc;
  logic [DW-1:0]    sum;
  logic [CNT_W-1:0] cnt, tgt, len_eff;

  fp32adder u_add (
    .a (acc),
    .b (in_data),
    .y (sum)
  );

  assign len_eff   = (len == '0) ? ONE : len;
  // Handshake flags decode the state register only, never the live inputs.
  assign in_ready  = (state != DONE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_data  = acc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= FP32_ZERO;
      cnt   <= '0;
      tgt   <= '0;
    end else if (clr) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          // Raw copy keeps a leading -0.0 intact.
          acc   <= in_data;
          cnt   <= ONE;
          tgt   <= len_eff;
          state <= (len_eff == ONE) ? DONE : ACC;
        end
        ACC: if (in_valid) begin
          acc <= sum;
          cnt <= cnt + ONE;
          if (cnt + ONE == tgt) state <= DONE;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FAN_ACC_NAN_FLAG_EN
  logic nan_q;
  assign nan_flag = nan_q;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) nan_q <= 1'b0;
    else if (state == IDLE && in_valid) nan_q <= is_exp_max(in_data);
    else if (state == ACC && in_valid)  nan_q <= nan_q | is_exp_max(in_data);
  end
`endif

endmodule

// File: tb/tb_fan_psum_accum.sv
// Bench for fan_psum_accum: directed cases plus randomized groups checked against an integer-sum model.
module tb_fan_psum_accum;
  import fan_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, clr, in_valid, in_ready, out_valid, out_ready, busy;
  logic [7:0]  len;
  logic [31:0] in_data, out_data;
`ifdef FAN_ACC_NAN_FLAG_EN
  logic        nan_flag;
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fan_psum_accum dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
`ifdef FAN_ACC_NAN_FLAG_EN
    ,.nan_flag (nan_flag)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Exact FP32 encoding of a small integer (|v| < 2^24).
  function automatic logic [31:0] int2fp(input int v);
    int mag, p;
    logic [31:0] m32;
    if (v == 0) return 32'h0;
    mag = (v < 0) ? -v : v;
    p = 0;
    for (int i = 0; i < 24; i++) if ((mag >> i) != 0) p = i;
    m32 = 32'(mag) << (23 - p);
    return {v < 0, 8'(127 + p), m32[22:0]};
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic beat(input logic [31:0] d, input logic [7:0] l);
    in_valid = 1'b1; in_data = d; len = l;
    step();
    in_valid = 1'b0;
  endtask

  int  cnt_m, tgt_m, sum_m, exp_m, v;
  bit  pend;

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    len = 8'd0; in_data = 32'h0;
    step(); step();
    chk("rst_ov",   32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_data", out_data, 32'h0);
    rst_n = 1'b1;
    step();
    chk("rst_ir",   32'(in_ready), 32'd1);

    // 1+2+3+4 back to back
    for (int i = 0; i < 4; i++) begin
      chk("t1_ov_early", 32'(out_valid), 32'd0);
      in_valid = 1'b1; in_data = int2fp(i + 1); len = 8'd4;
      step();
    end
    in_valid = 1'b0;
    chk("t1_ov",   32'(out_valid), 32'd1);
    chk("t1_data", out_data, 32'h4120_0000);
    step();
    chk("t1_busy", 32'(busy), 32'd0);

    // len 0 acts as 1, -0.0 survives
    beat(32'h8000_0000, 8'd0);
    chk("t2_ov",   32'(out_valid), 32'd1);
    chk("t2_data", out_data, 32'h8000_0000);
    step();

    // backpressure in DONE, in_valid pulses ignored
    out_ready = 1'b0;
    beat(32'h4000_0000, 8'd2);
    beat(32'h4040_0000, 8'd2);
    for (int i = 0; i < 5; i++) begin
      chk("t3_ov",   32'(out_valid), 32'd1);
      chk("t3_data", out_data, 32'h40A0_0000);
      chk("t3_ir",   32'(in_ready), 32'd0);
      in_valid = i[0]; in_data = 32'h4F00_0000; len = 8'd1;
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("t3_hold", out_data, 32'h40A0_0000);
    step();
    chk("t3_done", 32'(out_valid), 32'd0);
    chk("t3_idle", 32'(busy), 32'd0);

    // abort mid-group
    beat(32'h3F80_0000, 8'd3);
    beat(32'h4000_0000, 8'd3);
    clr = 1'b1;
    beat(32'h4100_0000, 8'd3);
    clr = 1'b0;
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_ov",   32'(out_valid), 32'd0);
    beat(32'h4080_0000, 8'd1);
    chk("t4_ov2",  32'(out_valid), 32'd1);
    chk("t4_data", out_data, 32'h4080_0000);
    step();

    // gapped input
    beat(32'h3F80_0000, 8'd3);
    step(); step();
    beat(32'h4000_0000, 8'd0);
    step();
    beat(32'h4040_0000, 8'd7);
    chk("t5_ov",   32'(out_valid), 32'd1);
    chk("t5_data", out_data, 32'h40C0_0000);
    step();

    // reset mid-group
    beat(32'h3F80_0000, 8'd3);
    chk("t6_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    step();
    chk("t6_data", out_data, 32'h0);
    chk("t6_ov",   32'(out_valid), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    step();
    chk("t6_ir",   32'(in_ready), 32'd1);

`ifdef FAN_ACC_NAN_FLAG_EN
    beat(32'h7FC0_0000, 8'd2);
    beat(32'h3F80_0000, 8'd2);
    chk("nan_ov",   32'(out_valid), 32'd1);
    chk("nan_flag", 32'(nan_flag), 32'd1);
    step();
    beat(32'h3F80_0000, 8'd2);
    beat(32'h3F80_0000, 8'd2);
    chk("nan_clean", 32'(nan_flag), 32'd0);
    chk("nan_data",  out_data, 32'h4000_0000);
    step();
`endif

    // randomized groups, gaps, len churn and backpressure
    cnt_m = 0; tgt_m = 0; sum_m = 0; exp_m = 0; pend = 1'b0;
    for (int cyc = 0; cyc < 420; cyc++) begin
      chk("rnd_ov", 32'(out_valid), 32'(pend));
      chk("rnd_ir", 32'(in_ready), 32'(!pend));
      if (pend) begin
        chk("rnd_data", out_data, int2fp(exp_m));
`ifdef FAN_ACC_NAN_FLAG_EN
        chk("rnd_nan", 32'(nan_flag), 32'd0);
`endif
      end
      v = int'($urandom_range(0, 1000)) - 500;
      in_valid  = (cyc < 380) && ($urandom_range(0, 2) != 0);
      in_data   = int2fp(v);
      len       = 8'($urandom_range(0, 5));
      out_ready = (cyc >= 380) || ($urandom_range(0, 3) != 0);
      if (pend && out_ready) begin
        pend = 1'b0;
      end else if (in_valid && !pend) begin
        if (cnt_m == 0) begin
          tgt_m = (len == 0) ? 1 : int'(len);
          sum_m = v;
        end else begin
          sum_m += v;
        end
        cnt_m++;
        if (cnt_m == tgt_m) begin
          pend  = 1'b1;
          exp_m = sum_m;
          cnt_m = 0;
        end
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
